// File: rtl/control_sequencer.sv
// Instruction register, flags and T-state sequencer producing the 8-bit computer's control word.
// Optional CTRL_EARLY_STEP_RESET_EN: each instruction ends after its last active step instead of using all STEPS.
module control_sequencer #(
  parameter int STEPS = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] bus_in,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic [3:0] ir_operand,
  output logic       HLT,
  output logic       MI,
  output logic       RI,
  output logic       RO,
  output logic       IO,
  output logic       II,
  output logic       AI,
  output logic       AO,
  output logic       EO,
  output logic       SU,
  output logic       BI,
  output logic       OI,
  output logic       CE,
  output logic       CO,
  output logic       J,
  output logic       FI,
  output logic [2:0] step,
  output logic [7:0] ir,
  output logic       carry_flag,
  output logic       zero_flag
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  typedef struct packed {
    logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
  } ctrl_t;

  localparam logic [2:0] LAST_FIXED = 3'(STEPS - 1);

  ctrl_t      ctrl;
  logic [2:0] step_nxt;
  logic [2:0] last_step;
  logic       halted;
  opcode_t    op;

  assign op         = opcode_t'(ir[7:4]);
  assign ir_operand = ir[3:0];
  assign {HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI} = ctrl;

`ifdef CTRL_EARLY_STEP_RESET_EN
  function automatic logic [2:0] last_of(input logic [3:0] opc);
    case (opc)
      OP_LDA, OP_STA:                              last_of = 3'd3;
      OP_ADD, OP_SUB:                              last_of = 3'd4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_of = 3'd2;
      default:                                     last_of = 3'd1;
    endcase
  endfunction

  // During T1 the new opcode is still on the bus, not yet in ir.
  logic [3:0] op_now;
  assign op_now    = (step == 3'd1) ? bus_in[7:4] : ir[7:4];
  assign last_step = last_of(op_now);
`else
  assign last_step = LAST_FIXED;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step       <= 3'd0;
      ir         <= 8'h00;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      step <= step_nxt;
      if (ctrl.ii) ir <= bus_in;
      if (ctrl.fi) begin
        carry_flag <= alu_carry;
        zero_flag  <= alu_zero;
      end
    end
  end

  always_comb begin
    ctrl     = '0;
    halted   = (step == 3'd2) && (op == OP_HLT);
    step_nxt = halted ? step : (step == last_step) ? 3'd0 : step + 3'd1;
    case (step)
      3'd0: begin ctrl.co = 1'b1; ctrl.mi = 1'b1; end
      3'd1: begin ctrl.ro = 1'b1; ctrl.ii = 1'b1; ctrl.ce = 1'b1; end
      3'd2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ctrl.io = 1'b1; ctrl.mi = 1'b1; end
          OP_LDI: begin ctrl.io = 1'b1; ctrl.ai = 1'b1; end
          OP_JMP: begin ctrl.io = 1'b1; ctrl.j = 1'b1; end
          OP_JC:  begin ctrl.io = carry_flag; ctrl.j = carry_flag; end
          OP_JZ:  begin ctrl.io = zero_flag;  ctrl.j = zero_flag;  end
          OP_OUT: begin ctrl.ao = 1'b1; ctrl.oi = 1'b1; end
          OP_HLT: ctrl.hlt = 1'b1;
          default: ;
        endcase
      end
      3'd3: begin
        case (op)
          OP_LDA:         begin ctrl.ro = 1'b1; ctrl.ai = 1'b1; end
          OP_ADD, OP_SUB: begin ctrl.ro = 1'b1; ctrl.bi = 1'b1; end
          OP_STA:         begin ctrl.ao = 1'b1; ctrl.ri = 1'b1; end
          default: ;
        endcase
      end
      3'd4: begin
        if (op == OP_ADD || op == OP_SUB) begin
          ctrl.eo = 1'b1;
          ctrl.ai = 1'b1;
          ctrl.fi = 1'b1;
          ctrl.su = (op == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected T-state/control word queued per cycle, checked mid-cycle.
module tb_control_sequencer;

`ifdef CTRL_EARLY_STEP_RESET_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [15:0] M_HLT = 16'h8000, M_MI = 16'h4000, M_RI = 16'h2000, M_RO = 16'h1000,
                          M_IO  = 16'h0800, M_II = 16'h0400, M_AI = 16'h0200, M_AO = 16'h0100,
                          M_EO  = 16'h0080, M_SU = 16'h0040, M_BI = 16'h0020, M_OI = 16'h0010,
                          M_CE  = 16'h0008, M_CO = 16'h0004, M_J  = 16'h0002, M_FI = 16'h0001;

  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] bus_in = 8'h00;
  logic alu_carry = 1'b0, alu_zero = 1'b0;
  logic [3:0] ir_operand;
  logic HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI;
  logic [2:0] step;
  logic [7:0] ir;
  logic carry_flag, zero_flag;
  logic [15:0] ctrl_w;

  control_sequencer #(.STEPS(5)) dut (
    .clock(clock), .reset(reset), .bus_in(bus_in), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .ir_operand(ir_operand), .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .IO(IO), .II(II), .AI(AI),
    .AO(AO), .EO(EO), .SU(SU), .BI(BI), .OI(OI), .CE(CE), .CO(CO), .J(J), .FI(FI),
    .step(step), .ir(ir), .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  assign ctrl_w = {HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI};

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  step;
    logic [15:0] ctrl;
    logic [7:0]  ir;
    logic        cf, zf;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  int m_step = 0;
  logic [7:0] m_ir = 8'h00;
  logic m_cf = 1'b0, m_zf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_ctrl(input logic [3:0] op, input int st, input logic cf, input logic zf);
    logic [15:0] w;
    w = 16'h0;
    case (st)
      0: w = M_CO | M_MI;
      1: w = M_RO | M_II | M_CE;
      2: case (op)
           4'h1, 4'h2, 4'h3, 4'h4: w = M_IO | M_MI;
           4'h5: w = M_IO | M_AI;
           4'h6: w = M_IO | M_J;
           4'h7: w = cf ? (M_IO | M_J) : 16'h0;
           4'h8: w = zf ? (M_IO | M_J) : 16'h0;
           4'hE: w = M_AO | M_OI;
           4'hF: w = M_HLT;
           default: w = 16'h0;
         endcase
      3: case (op)
           4'h1: w = M_RO | M_AI;
           4'h2, 4'h3: w = M_RO | M_BI;
           4'h4: w = M_AO | M_RI;
           default: w = 16'h0;
         endcase
      4: case (op)
           4'h2: w = M_EO | M_AI | M_FI;
           4'h3: w = M_EO | M_AI | M_FI | M_SU;
           default: w = 16'h0;
         endcase
      default: w = 16'h0;
    endcase
    return w;
  endfunction

  function automatic int last_step(input logic [3:0] op);
    if (!EARLY) return 4;
    case (op)
      4'h1, 4'h4: return 3;
      4'h2, 4'h3: return 4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit m_halted();
    return (m_step == 2) && (m_ir[7:4] == 4'hF);
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle(input logic [7:0] b, input logic c, input logic z);
    exp_t e, got;
    e.step = 3'(m_step);
    e.ctrl = exp_ctrl(m_ir[7:4], m_step, m_cf, m_zf);
    e.ir   = m_ir;
    e.cf   = m_cf;
    e.zf   = m_zf;
    sb.push_back(e);
    bus_in = b; alu_carry = c; alu_zero = z;
    @(negedge clock);
    got = sb.pop_front();
    chk("step", step, got.step);
    chk("ctrl", ctrl_w, got.ctrl);
    chk("ir", ir, got.ir);
    chk("ir_operand", ir_operand, got.ir[3:0]);
    chk("carry_flag", carry_flag, got.cf);
    chk("zero_flag", zero_flag, got.zf);
    @(posedge clock);
    if (!m_halted()) begin
      if ((got.ctrl & M_II) != 0) m_ir = b;
      if ((got.ctrl & M_FI) != 0) begin m_cf = c; m_zf = z; end
      m_step = (m_step == last_step(m_ir[7:4])) ? 0 : m_step + 1;
    end
    #1;
  endtask

  task automatic run_instr(input logic [7:0] instr, input logic c, input logic z);
    int n;
    n = 0;
    do begin
      cycle(instr, c, z);
      n++;
    end while (m_step != 0 && !m_halted() && n < 8);
  endtask

  task automatic model_reset();
    m_step = 0; m_ir = 8'h00; m_cf = 1'b0; m_zf = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_step", step, 3'd0);
    chk("rst_ctrl", ctrl_w, M_CO | M_MI);
    chk("rst_ir", ir, 8'h00);
    chk("rst_cf", carry_flag, 1'b0);
    chk("rst_zf", zero_flag, 1'b0);
    reset = 1'b0;
    model_reset();

    run_instr(8'h1E, 1'b0, 1'b0);  // LDA
    run_instr(8'h2F, 1'b1, 1'b0);  // ADD -> carry set
    run_instr(8'h73, 1'b0, 1'b0);  // JC taken
    run_instr(8'h3F, 1'b0, 1'b1);  // SUB -> zero set, carry clear
    run_instr(8'h73, 1'b0, 1'b0);  // JC not taken
    run_instr(8'h85, 1'b0, 1'b0);  // JZ taken
    run_instr(8'h2F, 1'b0, 1'b0);  // ADD -> zero clear
    run_instr(8'h85, 1'b0, 1'b0);  // JZ not taken
    run_instr(8'h57, 1'b0, 1'b0);  // LDI
    run_instr(8'h00, 1'b0, 1'b0);  // NOP
    run_instr(8'hE0, 1'b0, 1'b0);  // OUT
    run_instr(8'h4C, 1'b0, 1'b0);  // STA
    run_instr(8'h6A, 1'b0, 1'b0);  // JMP
    run_instr(8'h9A, 1'b0, 1'b0);  // undefined opcode
    run_instr(8'hF0, 1'b0, 1'b0);  // HLT reaches T2
    chk("hlt_reached", m_halted(), 1'b1);
    repeat (20) cycle(8'h1E, 1'b1, 1'b1);

    // Asynchronous reset between edges.
    #1 reset = 1'b1;
    #1;
    chk("async_step", step, 3'd0);
    chk("async_hlt", HLT, 1'b0);
    chk("async_ctrl", ctrl_w, M_CO | M_MI);
    chk("async_ir", ir, 8'h00);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_rst_step", step, 3'd1);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    run_instr(8'h57, 1'b0, 1'b0);
    run_instr(8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
